// File: rtl/alt_eyemon_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alt_eyemon_sweep_ctrl
// Description : Eye-monitor phase sweep sequencer: CRAM phase write, settle,
//               error-count dwell and per-step (phase, errcnt) result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alt_eyemon_sweep_ctrl #(
  parameter int DWELL_W  = 16,
  parameter int ERRCNT_W = 16,
  parameter int SETTLE   = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [5:0]          i_first_phase,
  input  logic [5:0]          i_last_phase,
  input  logic [DWELL_W-1:0]  i_dwell,
  input  logic                i_err,
  output logic                o_cram_wr,
  output logic [5:0]          o_cram_data,
  input  logic                i_cram_ack,
  output logic                o_res_valid,
  output logic [5:0]          o_res_phase,
  output logic [ERRCNT_W-1:0] o_res_errcnt,
  input  logic                i_res_ready,
  output logic                o_busy,
  output logic                o_done
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DWELL  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]          r_state;
  logic [5:0]          r_cur;
  logic [5:0]          r_last;
  logic [DWELL_W-1:0]  r_dwell_end;
  logic [DWELL_W-1:0]  r_dwell_cnt;
  logic [SET_W-1:0]    r_settle_cnt;
  logic [ERRCNT_W-1:0] r_errcnt;

  // User-linear phase index to hardware CRAM code, one quadrant per 16 steps.
  function automatic logic [5:0] phase_to_code(input logic [5:0] u);
    case (u[5:4])
      2'b00:   phase_to_code = 6'd63 - u;
      2'b01:   phase_to_code = u;
      2'b10:   phase_to_code = 6'd47 - u;
      default: phase_to_code = u - 6'd16;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cur        <= '0;
      r_last       <= '0;
      r_dwell_end  <= '0;
      r_dwell_cnt  <= '0;
      r_settle_cnt <= '0;
      r_errcnt     <= '0;
    end else if (i_abort && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            r_cur       <= i_first_phase;
            r_last      <= i_last_phase;
            // A zero dwell still gives a one-cycle window.
            r_dwell_end <= (i_dwell == '0) ? '0 : (i_dwell - DWELL_W'(1));
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (i_cram_ack) begin
            r_settle_cnt <= '0;
            r_errcnt     <= '0;
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == SET_W'(SETTLE - 1)) begin
            r_dwell_cnt <= '0;
            r_state     <= S_DWELL;
          end else begin
            r_settle_cnt <= r_settle_cnt + SET_W'(1);
          end
        end
        S_DWELL: begin
          if (i_err && (r_errcnt != '1)) begin
            r_errcnt <= r_errcnt + ERRCNT_W'(1);
          end
          if (r_dwell_cnt == r_dwell_end) begin
            r_state <= S_REPORT;
          end else begin
            r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
          end
        end
        S_REPORT: begin
          if (i_res_ready) begin
            if (r_cur == r_last) begin
              r_state <= S_DONE;
            end else begin
              r_cur   <= r_cur + 6'd1;
              r_state <= S_WRITE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated by state so that reset and abort leave every output at 0.
  assign o_cram_wr    = (r_state == S_WRITE);
  assign o_cram_data  = (r_state == S_WRITE) ? phase_to_code(r_cur) : 6'd0;
  assign o_res_valid  = (r_state == S_REPORT);
  assign o_res_phase  = (r_state == S_REPORT) ? r_cur : 6'd0;
  assign o_res_errcnt = (r_state == S_REPORT) ? r_errcnt : '0;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alt_eyemon_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alt_eyemon_sweep_ctrl
// Description : Scoreboard bench for alt_eyemon_sweep_ctrl; a second instance
//               with a 2-bit error counter shares all inputs to check saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alt_eyemon_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, err, cram_ack, res_ready;
  logic [5:0]  first_phase, last_phase;
  logic [15:0] dwell;

  logic        cram_wr, res_valid, busy, done;
  logic [5:0]  cram_data, res_phase;
  logic [15:0] res_errcnt;
  logic        cram_wr_b, res_valid_b, busy_b, done_b;
  logic [5:0]  cram_data_b, res_phase_b;
  logic [1:0]  res_errcnt_b;

  always #5 clk = ~clk;

  alt_eyemon_sweep_ctrl #(.DWELL_W(16), .ERRCNT_W(16), .SETTLE(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_first_phase(first_phase), .i_last_phase(last_phase), .i_dwell(dwell),
    .i_err(err), .o_cram_wr(cram_wr), .o_cram_data(cram_data), .i_cram_ack(cram_ack),
    .o_res_valid(res_valid), .o_res_phase(res_phase), .o_res_errcnt(res_errcnt),
    .i_res_ready(res_ready), .o_busy(busy), .o_done(done)
  );

  alt_eyemon_sweep_ctrl #(.DWELL_W(16), .ERRCNT_W(2), .SETTLE(4)) u_dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_first_phase(first_phase), .i_last_phase(last_phase), .i_dwell(dwell),
    .i_err(err), .o_cram_wr(cram_wr_b), .o_cram_data(cram_data_b), .i_cram_ack(cram_ack),
    .o_res_valid(res_valid_b), .o_res_phase(res_phase_b), .o_res_errcnt(res_errcnt_b),
    .i_res_ready(res_ready), .o_busy(busy_b), .o_done(done_b)
  );

  typedef struct {
    logic [5:0] phase;
    logic [5:0] code;
    int         errcnt;
  } step_t;

  step_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_code(input int u);
    if (u < 16)      return 6'(63 - u);
    else if (u < 32) return 6'(u);
    else if (u < 48) return 6'(47 - u);
    else             return 6'(u - 16);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_wr"}, 32'(cram_wr), 0);
    check({tag, "_data"}, 32'(cram_data), 0);
    check({tag, "_valid"}, 32'(res_valid), 0);
    check({tag, "_phase"}, 32'(res_phase), 0);
    check({tag, "_errcnt"}, 32'(res_errcnt), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic start_sweep(input int f, input int l, input int dw, input logic e);
    int u;
    int ec;
    first_phase = 6'(f);
    last_phase  = 6'(l);
    dwell       = 16'(dw);
    err         = e;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ec = e ? ((dw == 0) ? 1 : dw) : 0;
    u  = f;
    forever begin
      sb.push_back('{phase: 6'(u), code: exp_code(u), errcnt: ec});
      if (u == l) break;
      u = (u + 1) % 64;
    end
  endtask

  // Services the CRAM port and result handshake for every queued step.
  task automatic run_steps(input int dw, input int stall_cycles);
    step_t s;
    int    n;
    int    len;
    bit    first_step;
    len = (dw == 0) ? 1 : dw;
    first_step = 1'b1;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      n = 0;
      while (!cram_wr && n < 50) begin @(negedge clk); n++; end
      check("cram_wr", 32'(cram_wr), 1);
      check("cram_data", 32'(cram_data), 32'(s.code));
      @(negedge clk);
      check("cram_hold", 32'({cram_wr, cram_data}), 32'({1'b1, s.code}));
      check("busy", 32'(busy), 1);
      cram_ack = 1'b1;
      @(negedge clk);
      cram_ack = 1'b0;
      n = 1;
      while (!res_valid && n < 2000) begin @(negedge clk); n++; end
      check("latency", 32'(n), 32'(5 + len));
      check("res_phase", 32'(res_phase), 32'(s.phase));
      check("res_errcnt", 32'(res_errcnt), 32'(s.errcnt));
      check("sat_errcnt", 32'(res_errcnt_b), 32'((s.errcnt > 3) ? 3 : s.errcnt));
      if (first_step && stall_cycles > 0) begin
        // Start with a different config while busy must not disturb the sweep.
        first_phase = 6'd33;
        last_phase  = 6'd33;
        start       = 1'b1;
        for (int i = 0; i < stall_cycles; i++) begin
          @(negedge clk);
          check("stall_hold", 32'({res_valid, res_phase, res_errcnt}),
                32'({1'b1, s.phase, 16'(s.errcnt)}));
          check("stall_nowr", 32'(cram_wr), 0);
        end
        start = 1'b0;
      end
      first_step = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("done_pulse", 32'(done), (sb.size() == 0) ? 1 : 0);
      if (sb.size() == 0) begin
        @(negedge clk);
        check("done_clear", 32'({done, busy}), 0);
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; err = 1'b0;
    cram_ack = 1'b0; res_ready = 1'b0;
    first_phase = '0; last_phase = '0; dwell = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    start_sweep(0, 3, 8, 1'b0);
    run_steps(8, 0);
    start_sweep(14, 17, 5, 1'b1);
    run_steps(5, 0);
    start_sweep(62, 1, 10, 1'b1);
    run_steps(10, 0);
    start_sweep(20, 21, 3, 1'b1);
    run_steps(3, 20);

    // Abort and start together in IDLE: abort wins.
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_start_idle", 32'(busy), 0);

    // Abort while a CRAM write is pending, then a late ack.
    start_sweep(5, 9, 8, 1'b0);
    n = 0;
    while (!cram_wr && n < 50) begin @(negedge clk); n++; end
    check("abort_wr_seen", 32'(cram_wr), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle_outputs("abort_write");
    cram_ack = 1'b1;
    @(negedge clk);
    cram_ack = 1'b0;
    @(negedge clk);
    check("late_ack_idle", 32'({busy, cram_wr}), 0);
    sb.delete();

    // Abort in DWELL: ack edge + 4 settle cycles + 2 into the dwell.
    start_sweep(5, 9, 8, 1'b1);
    n = 0;
    while (!cram_wr && n < 50) begin @(negedge clk); n++; end
    cram_ack = 1'b1;
    @(negedge clk);
    cram_ack = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_abort_busy", 32'({busy, cram_wr, res_valid}), 32'(3'b100));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle_outputs("abort_dwell");
    n = 0;
    repeat (5) begin @(negedge clk); if (done || busy) n++; end
    check("abort_no_done", 32'(n), 0);
    sb.delete();

    start_sweep(8, 9, 2, 1'b1);
    run_steps(2, 0);

    start_sweep(40, 40, 0, 1'b1);
    run_steps(0, 0);

    // Reset in the middle of DWELL.
    start_sweep(40, 40, 100, 1'b1);
    n = 0;
    while (!cram_wr && n < 50) begin @(negedge clk); n++; end
    cram_ack = 1'b1;
    @(negedge clk);
    cram_ack = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("reset_dwell");
    n = 0;
    repeat (120) begin @(negedge clk); if (res_valid || busy) n++; end
    check("reset_no_result", 32'(n), 0);
    sb.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
